// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned shift-add multiply and restoring divide with HI/LO registers
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [3:0] OP_MUL = 4'b0011,
  parameter logic [3:0] OP_DIV = 4'b0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       AluOP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] opd;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0] sum, t, diff;
  logic accept;
  assign accept = start & ~flush & (state == IDLE) & (AluOP == OP_MUL || AluOP == OP_DIV);
  assign stall = busy | accept;
  // acc holds {partial, operand bits}: MUL adds into the top and shifts right, DIV shifts left and trial-subtracts
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    t = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = t - {1'b0, opd};
    acc_nxt = state == MUL ? {sum, acc[WIDTH-1:1]} :
              diff[WIDTH] ? {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                            {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
  // sequencer: accept, iterate WIDTH times, publish Hi/Lo on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      Hi <= '0;
      Lo <= '0;
      cnt <= '0;
      acc <= '0;
      opd <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= AluOP == OP_MUL ? MUL : DIV;
          busy <= 1'b1;
          cnt <= '0;
          opd <= AluOP == OP_MUL ? X : Y;
          acc <= {{WIDTH{1'b0}}, AluOP == OP_MUL ? Y : X};
        end
        DONE: state <= IDLE;
        default: if (flush) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            {Hi, Lo} <= acc_nxt;
          end
        end
      endcase
    end
  end
endmodule
